ahb_master_arbiter: RTL and testbench
=====================================

Name: ahb_master_arbiter

Overview:
Shares the single AHB-Lite master port between two requesters, the instruction-fetch unit and the load/store unit. It feeds the interconnect's haddr/htrans/hwrite/hsize/hprot/hwdata/is_signed inputs and consumes its muxed hr_data/hready/hresp. The block sequences non-pipelined single transfers (address phase, then data phase), arbitrates round-robin on contention and returns read data, completion and error per requester.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 16, data-phase wait-state limit (used only with ARB_TIMEOUT_EN)

Ports:
hclk  in  1  clock
hresetn  in  1  synchronous active-low reset
i_req  in  1  fetch request; held with i_addr stable until i_ack
i_addr  in  ADDR_W  fetch address (word-sized read)
i_ack  out  1  one-cycle completion pulse
i_rdata  out  DATA_W  fetch data, valid with i_ack
i_err  out  1  error flag, valid with i_ack
d_req  in  1  LSU request; held with attributes stable until d_ack
d_write  in  1  1=write
d_addr  in  ADDR_W  LSU address
d_size  in  3  AHB hsize encoding
d_wdata  in  DATA_W  write data
d_signed  in  1  signed-load flag
d_ack  out  1  one-cycle completion pulse
d_rdata  out  DATA_W  load data, valid with d_ack
d_err  out  1  error flag, valid with d_ack
haddr  out  ADDR_W  to interconnect
htrans  out  2  IDLE=2'b00, NONSEQ=2'b10
hwrite  out  1  to interconnect
hsize  out  3  to interconnect
hprot  out  4  fetch 4'b0010, data 4'b0011
hwdata  out  DATA_W  data-phase write data
is_signed  out  1  to interconnect
hrdata  in  DATA_W  from interconnect hr_data
hready  in  1  from interconnect
hresp  in  1  from interconnect, 1=ERROR
owner  out  1  0=fetch, 1=LSU; current/last grant
busy  out  1  1 in ADDR or DATA

Behaviour:
- Clock hclk. Reset hresetn is synchronous, active-low: at the edge with hresetn=0 the state becomes IDLE, all outputs go to 0 (htrans=IDLE, owner=0, acks=0), last-grant resets to LSU (fetch wins first tie), and any in-flight transfer is dropped without ack.
- FSM IDLE -> ADDR -> DATA -> IDLE. All bus outputs are registered.
- IDLE: if any req is present, grant and latch attributes. Fetch forces hwrite=0, hsize=3'b010, is_signed=0. Next state is ADDR with htrans=NONSEQ.
- Contention (both reqs in the same IDLE cycle): grant the requester not granted last. A single request is always granted.
- ADDR: hold htrans=NONSEQ and the address/control. On hready=1, go to DATA: htrans=IDLE, hwdata=latched wdata (0 for reads). With hready=0, stay in ADDR.
- DATA: wait while hready=0. On hready=1, pulse the owner's ack combinationally in the same cycle, with rdata=hrdata and err=hresp, then go to IDLE. The non-owner ack is 0.
- Two-cycle AHB error: hresp is sampled only when hready=1.
- Zero-wait latency: req sampled at cycle N, ADDR at N+1, ack at N+2. Requesters may drop or change req from the cycle after ack. The arbiter never re-samples a req during its own ack cycle.
- Only one transfer is outstanding; there is no back-to-back pipelining. The minimum spacing between grants is 3 cycles.
- busy=1 in ADDR/DATA. owner is valid while busy and holds its value in IDLE.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a wait counter clears on entry to DATA and increments each DATA cycle with hready=0. When it reaches TIMEOUT_CYCLES, the block pulses the owner ack with err=1 and rdata=0, returns to IDLE and sets htrans=IDLE.
- Undefined: no counter; DATA waits indefinitely.

Decomposition:
- Package ahb_arb_pkg: htrans constants (HTRANS_IDLE, HTRANS_NONSEQ), HPROT_FETCH/HPROT_DATA, HSIZE_WORD, state enum arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA}, owner enum.
- Sub-module ahb_rr_arb2: 2-way round-robin picker with last-grant register; inputs req[1:0], update strobe; output grant index.

Test Plan:
- Fetch only, i_addr=0x0000_0100, hready=1, hrdata=0x0000_0013 -> htrans=NONSEQ at N+1 with hprot=4'b0010; i_ack=1 with i_rdata=0x13, i_err=0 at N+2.
- LSU write, d_addr=0x2000_0004, d_wdata=0xDEAD_BEEF, d_size=3'b010, 2 data-phase wait states -> hwdata=0xDEADBEEF during DATA; d_ack on the third DATA cycle.
- Both reqs held continuously for 6 transfers -> grants alternate fetch, LSU, fetch...; no ack goes to a non-owner.
- LSU read with two-cycle error (hresp=1/hready=0, then hresp=1/hready=1) -> d_ack=1, d_err=1 on the second cycle; then IDLE.
- hresetn=0 during DATA -> next edge htrans=0, busy=0, no ack; a request after reset is granted to fetch on a tie.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, hready stuck at 0 in DATA -> owner ack with err=1 after 4 DATA cycles; htrans=IDLE.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the two-requester AHB-Lite master arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [3:0] HPROT_FETCH = 4'b0010;
  localparam logic [3:0] HPROT_DATA  = 4'b0011;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_LSU   = 1'b1
  } owner_t;

endpackage

// File: rtl/ahb_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module ahb_rr_arb2
  import ahb_arb_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [1:0] req,
  input  logic       update,
  output owner_t     grant
);

  owner_t last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      last_q <= OWNER_LSU;
    end else if (update) begin
      last_q <= grant;
    end
  end

  // NOTE: a default assignment first keeps this block free of inferred latches.
  always_comb begin
    grant = OWNER_FETCH;
    if (req == 2'b11) begin
      grant = (last_q == OWNER_LSU) ? OWNER_FETCH : OWNER_LSU;
    end else if (req[1]) begin
      grant = OWNER_LSU;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port between fetch and LSU with non-pipelined single transfers.
// Optional data-phase watchdog enabled by defining ARB_TIMEOUT_EN.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_signed,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  output logic              is_signed,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              owner,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q;
  owner_t            grant;
  logic [DATA_W-1:0] wdata_q;
  logic              start;
  logic              timeout;
  logic              done;

  assign start = i_req | d_req;

  ahb_rr_arb2 u_rr (
    .hclk    (hclk),
    .hresetn (hresetn),
    .req     ({d_req, i_req}),
    .update  ((state_q == ARB_IDLE) && start),
    .grant   (grant)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside DATA, so it is already clear on entry.
  always_ff @(posedge hclk) begin
    if (!hresetn || (state_q != ARB_DATA)) begin
      wait_cnt <= '0;
    end else if (!hready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = (state_q == ARB_DATA) && !hready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // A real completion wins over the watchdog; reset suppresses any ack in flight.
  assign done = hresetn && (state_q == ARB_DATA) && (hready || timeout);

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (start)            state_d = ARB_ADDR;
      ARB_ADDR: if (hready)           state_d = ARB_DATA;
      ARB_DATA: if (hready || timeout) state_d = ARB_IDLE;
      default:                        state_d = ARB_IDLE;
    endcase
  end

  // Registered bus side: attributes latched at grant, wdata moved to hwdata on the address handshake.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      owner_q   <= OWNER_FETCH;
      haddr     <= '0;
      htrans    <= HTRANS_IDLE;
      hwrite    <= 1'b0;
      hsize     <= '0;
      hprot     <= '0;
      is_signed <= 1'b0;
      hwdata    <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (start) begin
            owner_q <= grant;
            htrans  <= HTRANS_NONSEQ;
            if (grant == OWNER_LSU) begin
              haddr     <= d_addr;
              hwrite    <= d_write;
              hsize     <= d_size;
              hprot     <= HPROT_DATA;
              is_signed <= d_signed;
              wdata_q   <= d_write ? d_wdata : '0;
            end else begin
              haddr     <= i_addr;
              hwrite    <= 1'b0;
              hsize     <= HSIZE_WORD;
              hprot     <= HPROT_FETCH;
              is_signed <= 1'b0;
              wdata_q   <= '0;
            end
          end
        end
        ARB_ADDR: begin
          if (hready) begin
            htrans <= HTRANS_IDLE;
            hwdata <= wdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q != ARB_IDLE);

  // Completion is returned combinationally in the final data-phase cycle.
  always_comb begin
    i_ack   = 1'b0;
    i_rdata = '0;
    i_err   = 1'b0;
    d_ack   = 1'b0;
    d_rdata = '0;
    d_err   = 1'b0;
    if (done) begin
      if (owner_q == OWNER_LSU) begin
        d_ack   = 1'b1;
        d_rdata = timeout ? '0 : hrdata;
        d_err   = timeout | hresp;
      end else begin
        i_ack   = 1'b1;
        i_rdata = timeout ? '0 : hrdata;
        i_err   = timeout | hresp;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: directed vector table, reset/timeout sequences, randomized model check.
module tb_ahb_master_arbiter;

  logic        hclk;
  logic        hresetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [2:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_signed;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        is_signed;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        owner;
  logic        busy;

  ahb_master_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_size    (d_size),
    .d_wdata   (d_wdata),
    .d_signed  (d_signed),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hprot     (hprot),
    .hwdata    (hwdata),
    .is_signed (is_signed),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp),
    .owner     (owner),
    .busy      (busy)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        d_write;
    logic        d_signed;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    int          aw;       // address-phase wait states
    int          dw;       // data-phase wait states
    logic        resp;     // hresp driven throughout the data phase
    logic [31:0] rdata;    // hrdata driven during the data phase
    logic        e_owner;
    logic [31:0] e_addr;
    logic [3:0]  e_prot;
    logic        e_write;
    logic [2:0]  e_size;
    logic        e_signed;
    logic [31:0] e_wdata;
    logic        e_err;
  } vec_t;

  int   total  = 0;
  int   passed = 0;
  logic model_last;   // 1 = LSU was granted last

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  // Runs one full transfer starting from an IDLE cycle; returns one cycle after the ack.
  task automatic apply_vec(input vec_t v);
    i_req = v.i_req;   d_req = v.d_req;   i_addr = v.i_addr;
    d_addr = v.d_addr; d_write = v.d_write; d_size = v.d_size;
    d_wdata = v.d_wdata; d_signed = v.d_signed;
    hready = 1'b1; hresp = 1'b0;
    @(negedge hclk);
    check("idle_busy", 32'(busy), 32'(1'b0));
    check("idle_htrans", 32'(htrans), 32'(2'b00));
    next_cycle();
    for (int k = 0; k <= v.aw; k++) begin
      hready = (k == v.aw);
      @(negedge hclk);
      check("addr_htrans", 32'(htrans), 32'(2'b10));
      check("addr_haddr", haddr, v.e_addr);
      check("addr_hprot", 32'(hprot), 32'(v.e_prot));
      check("addr_hwrite", 32'(hwrite), 32'(v.e_write));
      check("addr_hsize", 32'(hsize), 32'(v.e_size));
      check("addr_signed", 32'(is_signed), 32'(v.e_signed));
      check("addr_owner", 32'(owner), 32'(v.e_owner));
      check("addr_busy", 32'(busy), 32'(1'b1));
      check("addr_no_ack", 32'({i_ack, d_ack}), 32'(2'b00));
      next_cycle();
    end
    for (int k = 0; k <= v.dw; k++) begin
      hready = (k == v.dw);
      hresp  = v.resp;
      hrdata = v.rdata;
      @(negedge hclk);
      check("data_htrans", 32'(htrans), 32'(2'b00));
      check("data_hwdata", hwdata, v.e_wdata);
      check("data_busy", 32'(busy), 32'(1'b1));
      if (k == v.dw) begin
        check("ack_i", 32'(i_ack), 32'(!v.e_owner));
        check("ack_d", 32'(d_ack), 32'(v.e_owner));
        check("ack_rdata", v.e_owner ? d_rdata : i_rdata, v.rdata);
        check("ack_err", 32'(v.e_owner ? d_err : i_err), 32'(v.e_err));
      end else begin
        check("wait_no_ack", 32'({i_ack, d_ack}), 32'(2'b00));
      end
      next_cycle();
    end
    if (v.e_owner) d_req = 1'b0;
    else           i_req = 1'b0;
    hready = 1'b1; hresp = 1'b0;
    model_last = v.e_owner;
  endtask

  vec_t vecs [10];

  logic        f_pend, l_pend, own;
  logic [31:0] ri_addr, rd_addr, rd_wdata;
  logic        rd_write, rd_signed;
  logic [2:0]  rd_size;
  vec_t        rv;

  initial begin
    // Fields: i_req d_req d_write d_signed i_addr d_addr d_wdata d_size aw dw resp rdata |
    //         e_owner e_addr e_prot e_write e_size e_signed e_wdata e_err
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 3'b010, 0, 0, 1'b0, 32'h0000_0013,
                1'b0, 32'h0000_0100, 4'b0010, 1'b0, 3'b010, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h2000_0004, 32'hDEAD_BEEF, 3'b010, 0, 2, 1'b0, 32'h0,
                1'b1, 32'h2000_0004, 4'b0011, 1'b1, 3'b010, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h3000_0000, 32'h0, 3'b000, 0, 1, 1'b1, 32'h0000_0055,
                1'b1, 32'h3000_0000, 4'b0011, 1'b0, 3'b000, 1'b1, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_1000, 32'h1111_1111, 3'b010, 0, 0, 1'b0, 32'hC0DE_0001,
                1'b0, 32'h0000_0400, 4'b0010, 1'b0, 3'b010, 1'b0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0000_1000, 32'h1111_1111, 3'b010, 0, 0, 1'b0, 32'h0,
                1'b1, 32'h0000_1000, 4'b0011, 1'b1, 3'b010, 1'b0, 32'h1111_1111, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0404, 32'h0000_2002, 32'h0, 3'b001, 0, 0, 1'b0, 32'hC0DE_0002,
                1'b0, 32'h0000_0404, 4'b0010, 1'b0, 3'b010, 1'b0, 32'h0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0408, 32'h0000_2002, 32'h0, 3'b001, 0, 0, 1'b0, 32'h0000_8001,
                1'b1, 32'h0000_2002, 4'b0011, 1'b0, 3'b001, 1'b1, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0408, 32'h0000_3000, 32'h0000_00A5, 3'b000, 0, 0, 1'b0, 32'hC0DE_0003,
                1'b0, 32'h0000_0408, 4'b0010, 1'b0, 3'b010, 1'b0, 32'h0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_040C, 32'h0000_3000, 32'h0000_00A5, 3'b000, 0, 0, 1'b0, 32'h0,
                1'b1, 32'h0000_3000, 4'b0011, 1'b1, 3'b000, 1'b0, 32'h0000_00A5, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0044, 32'h0, 3'b001, 2, 0, 1'b0, 32'hFFFF_8000,
                1'b1, 32'h0000_0044, 4'b0011, 1'b0, 3'b001, 1'b1, 32'h0, 1'b0};

    hresetn = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0; d_write = 1'b0;
    d_size = '0; d_wdata = '0; d_signed = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    model_last = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge hclk);
    check("rst_htrans", 32'(htrans), 32'(2'b00));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_owner", 32'(owner), 32'(1'b0));
    check("rst_haddr", haddr, 32'h0);
    check("rst_acks", 32'({i_ack, d_ack}), 32'(2'b00));
    next_cycle();
    hresetn = 1'b1;

    foreach (vecs[n]) apply_vec(vecs[n]);

    // Reset in the middle of a fetch data phase: no ack, bus idles, last-grant back to LSU.
    i_req = 1'b1; d_req = 1'b0; i_addr = 32'h0000_0500; hready = 1'b1; hrdata = 32'h77;
    next_cycle();
    next_cycle();
    hresetn = 1'b0;
    @(negedge hclk);
    check("rst_data_no_ack", 32'({i_ack, d_ack}), 32'(2'b00));
    next_cycle();
    i_req = 1'b0;
    hresetn = 1'b1;
    check("rst_data_htrans", 32'(htrans), 32'(2'b00));
    check("rst_data_busy", 32'(busy), 32'(1'b0));
    check("rst_data_owner", 32'(owner), 32'(1'b0));
    model_last = 1'b1;
    rv = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0000_0700, 32'h0, 3'b010, 0, 0, 1'b0, 32'h1234_5678,
           1'b0, 32'h0000_0600, 4'b0010, 1'b0, 3'b010, 1'b0, 32'h0, 1'b0};
    apply_vec(rv);
    d_req = 1'b0;

    // Randomized traffic; pending requesters keep their attributes until served.
    f_pend = 1'b0; l_pend = 1'b0;
    ri_addr = '0; rd_addr = '0; rd_wdata = '0; rd_write = 1'b0; rd_signed = 1'b0; rd_size = '0;
    for (int t = 0; t < 60; t++) begin
      if (!f_pend && ($urandom_range(1) == 1)) begin
        f_pend  = 1'b1;
        ri_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!l_pend && (($urandom_range(1) == 1) || !f_pend)) begin
        l_pend    = 1'b1;
        rd_addr   = $urandom;
        rd_wdata  = $urandom;
        rd_write  = 1'($urandom_range(1));
        rd_signed = 1'($urandom_range(1));
        rd_size   = 3'($urandom_range(2));
      end
      own = (f_pend && l_pend) ? !model_last : l_pend;
      rv.i_req = f_pend;       rv.d_req = l_pend;
      rv.d_write = rd_write;   rv.d_signed = rd_signed;
      rv.i_addr = ri_addr;     rv.d_addr = rd_addr;
      rv.d_wdata = rd_wdata;   rv.d_size = rd_size;
      rv.aw = $urandom_range(2);
      rv.dw = $urandom_range(3);
      rv.resp = ($urandom_range(3) == 0);
      rv.rdata = $urandom;
      rv.e_owner  = own;
      rv.e_addr   = own ? rd_addr : ri_addr;
      rv.e_prot   = own ? 4'b0011 : 4'b0010;
      rv.e_write  = own && rd_write;
      rv.e_size   = own ? rd_size : 3'b010;
      rv.e_signed = own && rd_signed;
      rv.e_wdata  = (own && rd_write) ? rd_wdata : 32'h0;
      rv.e_err    = rv.resp;
      apply_vec(rv);
      if (own) l_pend = 1'b0;
      else     f_pend = 1'b0;
      i_req = f_pend;
      d_req = l_pend;
    end
    i_req = 1'b0; d_req = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: data phase never completes, the owner gets an error ack after four stalled cycles.
    next_cycle();
    i_req = 1'b1; i_addr = 32'h0000_0800; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0000_0BAD;
    next_cycle();
    next_cycle();
    hready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      check("to_wait_no_ack", 32'(i_ack), 32'(1'b0));
      next_cycle();
    end
    @(negedge hclk);
    check("to_ack", 32'(i_ack), 32'(1'b1));
    check("to_err", 32'(i_err), 32'(1'b1));
    check("to_rdata", i_rdata, 32'h0);
    check("to_htrans", 32'(htrans), 32'(2'b00));
    next_cycle();
    i_req = 1'b0; hready = 1'b1;
    @(negedge hclk);
    check("to_idle_busy", 32'(busy), 32'(1'b0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
